tmds_encoder: RTL and testbench



---
 rtl/tmds_encoder.sv | 129 ++++++++++++
 tb/tb_tmds_encoder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// Per-channel DVI TMDS 8b/10b encoder: colour expansion, transition minimising, DC balancing.
// Optional build macro TMDS_ENCODER_DISPARITY_MON_EN exposes the disparity counter and a sticky range error.
module tmds_encoder #(
  parameter int C_depth = 8
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic [C_depth-1:0] in_data,
  input  logic               in_c0,
  input  logic               in_c1,
  input  logic               in_blank,
  output logic [9:0]         out_tmds
`ifdef TMDS_ENCODER_DISPARITY_MON_EN
  ,
  output logic signed [4:0]  out_disparity,
  output logic               out_disp_err
`endif
);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Reduced-depth colour is widened by repeating the input pattern from the MSB down.
  logic [7:0] d;
  for (genvar gi = 0; gi < 8; gi++) begin : g_expand
    assign d[7-gi] = in_data[C_depth-1-(gi % C_depth)];
  end

  logic [3:0] n1_d;
  logic       use_xnor;
  logic [8:0] q_m_next;

  always_comb begin
    n1_d     = popcount8(d);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
    q_m_next = '0;
    q_m_next[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ d[i]) : (q_m_next[i-1] ^ d[i]);
    end
    q_m_next[8] = ~use_xnor;
  end

  logic [8:0] q_m;
  logic       s1_blank;
  logic       s1_c0;
  logic       s1_c1;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      q_m      <= '0;
      s1_blank <= 1'b1;
      s1_c0    <= 1'b0;
      s1_c1    <= 1'b0;
    end else begin
      q_m      <= q_m_next;
      s1_blank <= in_blank;
      s1_c0    <= in_c0;
      s1_c1    <= in_c1;
    end
  end

  logic signed [4:0] cnt;
  logic signed [4:0] cnt_next;
  logic signed [4:0] diff;
  logic [3:0]        n1_q;
  logic [9:0]        sym;

  // Modular 5-bit arithmetic is enough: any real excursion past +/-8 lands outside +/-8 after wrap.
  always_comb begin
    n1_q     = popcount8(q_m[7:0]);
    diff     = $signed({n1_q, 1'b0}) - 5'sd8;
    sym      = '0;
    cnt_next = cnt;
    if (s1_blank) begin
      cnt_next = '0;
      case ({s1_c1, s1_c0})
        2'b00:   sym = TOK_00;
        2'b01:   sym = TOK_01;
        2'b10:   sym = TOK_10;
        default: sym = TOK_11;
      endcase
    end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
      sym      = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
      sym      = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym      = {1'b0, q_m[8], q_m[7:0]};
      cnt_next = cnt + diff - (q_m[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      out_tmds <= TOK_00;
      cnt      <= '0;
    end else begin
      out_tmds <= sym;
      cnt      <= cnt_next;
    end
  end

`ifdef TMDS_ENCODER_DISPARITY_MON_EN
  localparam logic signed [4:0] CNT_MAX = 5'sd8;
  localparam logic signed [4:0] CNT_MIN = -5'sd8;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      out_disp_err <= 1'b0;
    end else if ((cnt_next > CNT_MAX) || (cnt_next < CNT_MIN)) begin
      out_disp_err <= 1'b1;
    end
  end

  assign out_disparity = cnt;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: an 8-bit instance and a 3-bit instance run in lockstep against
// an arithmetic reference of the TMDS encoding rules and the DVI decode rule.
module tb_tmds_encoder;

  logic       clk_pixel;
  logic       reset;
  logic [7:0] in_data;
  logic [2:0] in_data3;
  logic       in_c0;
  logic       in_c1;
  logic       in_blank;
  logic [9:0] out_tmds;
  logic [9:0] out_tmds3;
`ifdef TMDS_ENCODER_DISPARITY_MON_EN
  logic signed [4:0] out_disparity;
  logic              out_disp_err;
  logic signed [4:0] out_disparity3;
  logic              out_disp_err3;
`endif

  int checks = 0;
  int errors = 0;

  tmds_encoder #(.C_depth(8)) u_dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .in_data   (in_data),
    .in_c0     (in_c0),
    .in_c1     (in_c1),
    .in_blank  (in_blank),
    .out_tmds  (out_tmds)
`ifdef TMDS_ENCODER_DISPARITY_MON_EN
    ,
    .out_disparity (out_disparity),
    .out_disp_err  (out_disp_err)
`endif
  );

  tmds_encoder #(.C_depth(3)) u_dut3 (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .in_data   (in_data3),
    .in_c0     (in_c0),
    .in_c1     (in_c1),
    .in_blank  (in_blank),
    .out_tmds  (out_tmds3)
`ifdef TMDS_ENCODER_DISPARITY_MON_EN
    ,
    .out_disparity (out_disparity3),
    .out_disp_err  (out_disp_err3)
`endif
  );

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  localparam logic [9:0] TOK00 = 10'b1101010100;

  // Reference state per instance: 0 = 8-bit, 1 = 3-bit.
  int         m_cnt       [2];
  logic       m_s1_blank  [2];
  logic [1:0] m_s1_c      [2];
  logic [7:0] m_s1_d      [2];
  logic [9:0] m_out       [2];
  logic       m_out_blank [2];
  logic [7:0] m_out_d     [2];

  function automatic logic [9:0] token(input logic [1:0] c);
    logic [9:0] t [4];
    t[0] = 10'b1101010100;
    t[1] = 10'b0010101011;
    t[2] = 10'b0101010100;
    t[3] = 10'b1010101011;
    return t[c];
  endfunction

  function automatic logic [7:0] expand3(input logic [2:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[2 - (i % 3)];
    return r;
  endfunction

  function automatic logic [9:0] encode(input logic [7:0] d, input int cnt_in, output int cnt_out);
    logic [7:0] qm;
    logic       qm8;
    logic       xnor_mode;
    int         ones;
    int         disp;
    logic [9:0] s;
    xnor_mode = ($countones(d) > 4) || (($countones(d) == 4) && (d[0] == 1'b0));
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xnor_mode ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm8  = !xnor_mode;
    ones = $countones(qm);
    disp = ones - (8 - ones);
    cnt_out = cnt_in;
    if (cnt_in == 0 || disp == 0) begin
      s = {~qm8, qm8, qm8 ? qm : ~qm};
      cnt_out = qm8 ? cnt_in + disp : cnt_in - disp;
    end else if ((cnt_in > 0 && disp > 0) || (cnt_in < 0 && disp < 0)) begin
      s = {1'b1, qm8, ~qm};
      cnt_out = cnt_in + (qm8 ? 2 : 0) - disp;
    end else begin
      s = {1'b0, qm8, qm};
      cnt_out = cnt_in + disp - (qm8 ? 0 : 2);
    end
    return s;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic model_advance(input int m, input logic [7:0] d);
    int nc;
    if (reset) begin
      m_out[m]       = TOK00;
      m_cnt[m]       = 0;
      m_out_blank[m] = 1'b1;
      m_out_d[m]     = 8'h00;
      m_s1_blank[m]  = 1'b1;
      m_s1_c[m]      = 2'b00;
      m_s1_d[m]      = 8'h00;
    end else begin
      if (m_s1_blank[m]) begin
        m_out[m]       = token(m_s1_c[m]);
        m_cnt[m]       = 0;
        m_out_blank[m] = 1'b1;
      end else begin
        m_out[m]       = encode(m_s1_d[m], m_cnt[m], nc);
        m_cnt[m]       = nc;
        m_out_blank[m] = 1'b0;
        m_out_d[m]     = m_s1_d[m];
      end
      m_s1_blank[m] = in_blank;
      m_s1_c[m]     = {in_c1, in_c0};
      m_s1_d[m]     = d;
    end
  endtask

  // Inputs change only at the falling edge; outputs are read there too.
  task automatic tick();
    @(posedge clk_pixel);
    model_advance(0, in_data);
    model_advance(1, expand3(in_data3));
    @(negedge clk_pixel);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_blank = 1'b0; in_data = 8'hFF; in_data3 = 3'b111;
    in_c0 = 1'b0; in_c1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_tmds !== TOK00) begin
        errors++; $display("FAIL reset_hold[%0d]: got %b expected %b", i, out_tmds, TOK00);
      end
`ifdef TMDS_ENCODER_DISPARITY_MON_EN
      checks++;
      if (out_disparity !== 5'sd0) begin
        errors++; $display("FAIL reset_disp[%0d]: got %0d expected 0", i, out_disparity);
      end
`endif
    end
    reset = 1'b0;
    tick();
    checks++;
    if (out_tmds !== TOK00) begin
      errors++; $display("FAIL reset_release1: got %b expected %b", out_tmds, TOK00);
    end
    tick();
    checks++;
    if (out_tmds !== 10'b1000000000) begin
      errors++; $display("FAIL reset_release2: got %b expected %b", out_tmds, 10'b1000000000);
    end
  endtask

  task automatic test_control();
    in_blank = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) {in_c1, in_c0} = k[1:0];
      tick();
      if (k >= 1) begin
        checks++;
        if (out_tmds !== token(2'(k - 1))) begin
          errors++; $display("FAIL control_token[%0d]: got %b expected %b", k - 1, out_tmds, token(2'(k - 1)));
        end
      end
    end
    in_c0 = 1'b0; in_c1 = 1'b0;
  endtask

  task automatic test_black();
    logic [9:0] exp_sym [4];
    int         exp_cnt [4];
    exp_sym[0] = 10'b0100000000; exp_sym[1] = 10'b1111111111;
    exp_sym[2] = 10'b0100000000; exp_sym[3] = 10'b1111111111;
    exp_cnt[0] = -8; exp_cnt[1] = 2; exp_cnt[2] = -6; exp_cnt[3] = 4;
    in_blank = 1'b1; in_c0 = 1'b0; in_c1 = 1'b0;
    tick(); tick();
    in_blank = 1'b0; in_data = 8'h00;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_tmds !== exp_sym[i]) begin
        errors++; $display("FAIL black_sym[%0d]: got %b expected %b", i, out_tmds, exp_sym[i]);
      end
`ifdef TMDS_ENCODER_DISPARITY_MON_EN
      checks++;
      if (int'(out_disparity) !== exp_cnt[i]) begin
        errors++; $display("FAIL black_cnt[%0d]: got %0d expected %0d", i, out_disparity, exp_cnt[i]);
      end
`endif
    end
  endtask

  task automatic test_depth();
    int         dummy;
    logic [9:0] first;
    in_blank = 1'b1; tick(); tick();
    in_blank = 1'b0; in_data3 = 3'b101; in_data = 8'hB6;
    tick(); tick();
    first = encode(8'hB6, 0, dummy);
    checks++;
    if (out_tmds3 !== first) begin
      errors++; $display("FAIL depth_101: got %b expected %b", out_tmds3, first);
    end
    for (int i = 0; i < 300; i++) begin
      in_data3 = 3'($urandom_range(0, 7));
      in_data  = 8'($urandom);
      in_blank = ($urandom_range(0, 7) == 0);
      {in_c1, in_c0} = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (out_tmds3 !== m_out[1]) begin
        errors++; $display("FAIL depth_rand[%0d]: got %b expected %b", i, out_tmds3, m_out[1]);
      end
    end
  endtask

  task automatic test_random();
    int gap;
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      if (gap == 0 && $urandom_range(0, 49) == 0) gap = $urandom_range(1, 20);
      in_blank = (gap > 0);
      if (gap > 0) gap--;
      in_data  = 8'($urandom);
      in_data3 = 3'($urandom_range(0, 7));
      {in_c1, in_c0} = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (out_tmds !== m_out[0]) begin
        errors++; $display("FAIL random_sym[%0d]: got %b expected %b", i, out_tmds, m_out[0]);
      end
      if (!m_out_blank[0]) begin
        checks++;
        if (decode(out_tmds) !== m_out_d[0]) begin
          errors++; $display("FAIL random_decode[%0d]: got %h expected %h", i, decode(out_tmds), m_out_d[0]);
        end
      end
`ifdef TMDS_ENCODER_DISPARITY_MON_EN
      checks++;
      if (int'(out_disparity) !== m_cnt[0] || m_cnt[0] > 8 || m_cnt[0] < -8) begin
        errors++; $display("FAIL random_cnt[%0d]: got %0d expected %0d", i, out_disparity, m_cnt[0]);
      end
      checks++;
      if (out_disp_err !== 1'b0) begin
        errors++; $display("FAIL random_err[%0d]: got %b expected 0", i, out_disp_err);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int         dummy;
    int         n;
    logic [9:0] exp_first;
    in_blank = 1'b0; in_data = 8'h01;
    n = 0;
    tick(); tick();
    while (m_cnt[0] == 0 && n < 20) begin
      in_data = 8'($urandom);
      tick();
      n++;
    end
    checks++;
    if (m_cnt[0] == 0) begin
      errors++; $display("FAIL midreset_setup: got cnt 0 expected nonzero within 20 cycles");
    end
    in_data = 8'h3C;
    reset = 1'b1;
    tick();
    checks++;
    if (out_tmds !== TOK00) begin
      errors++; $display("FAIL midreset_sym: got %b expected %b", out_tmds, TOK00);
    end
`ifdef TMDS_ENCODER_DISPARITY_MON_EN
    checks++;
    if (out_disparity !== 5'sd0) begin
      errors++; $display("FAIL midreset_cnt: got %0d expected 0", out_disparity);
    end
`endif
    reset = 1'b0;
    tick();
    checks++;
    if (out_tmds !== TOK00) begin
      errors++; $display("FAIL midreset_release: got %b expected %b", out_tmds, TOK00);
    end
    tick();
    exp_first = encode(8'h3C, 0, dummy);
    checks++;
    if (out_tmds !== exp_first) begin
      errors++; $display("FAIL midreset_first: got %b expected %b", out_tmds, exp_first);
    end
  endtask

  initial begin
    reset = 1'b1; in_blank = 1'b1; in_data = 8'h00; in_data3 = 3'b000;
    in_c0 = 1'b0; in_c1 = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_s1_blank[m] = 1'b1; m_s1_c[m] = 2'b00; m_s1_d[m] = 8'h00;
      m_out[m] = TOK00; m_out_blank[m] = 1'b1; m_out_d[m] = 8'h00;
    end
    test_reset();
    test_control();
    test_black();
    test_depth();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
